bank_result_checker: RTL and testbench



---
 rtl/bank_result_checker.sv | 157 +++++++++++++++
 tb/tb_bank_result_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_result_checker.sv
// Streams words out of a bank-striped output SRAM and compares the signed low
// slice of each against a golden stream within a runtime tolerance.
module bank_result_checker #(
  parameter int unsigned NUM_BANKS  = 6,
  parameter int unsigned BANK_DEPTH = 32768,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CMP_W      = 8,
  parameter int unsigned TOL_W      = 4,
  parameter int unsigned ERR_W      = 20,
  localparam int unsigned BA_W  = $clog2(NUM_BANKS),
  localparam int unsigned AD_W  = $clog2(BANK_DEPTH),
  localparam int unsigned CNT_W = $clog2(NUM_BANKS * BANK_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [BA_W-1:0]             beg_bank_i,
  input  logic [AD_W-1:0]             beg_addr_i,
  input  logic [CNT_W-1:0]            count_i,
  input  logic [TOL_W-1:0]            tol_i,
  output logic [NUM_BANKS-1:0]        mem_cs_o,
  output logic [AD_W-1:0]             mem_addr_o,
  input  logic [NUM_BANKS*DATA_W-1:0] mem_rdata_i,
  input  logic                        gold_valid_i,
  input  logic [DATA_W-1:0]           gold_data_i,
  output logic                        gold_ready_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        pass_o,
  output logic [ERR_W-1:0]            err_cnt_o,
  output logic [CNT_W-1:0]            chk_cnt_o,
  output logic [BA_W+AD_W-1:0]        first_err_idx_o,
  output logic                        first_err_vld_o,
  output logic                        range_err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [AD_W-1:0] LAST_ADDR = AD_W'(BANK_DEPTH - 1);
  localparam logic [BA_W-1:0] LAST_BANK = BA_W'(NUM_BANKS - 1);

  state_t              state;
  logic [BA_W-1:0]     bank;
  logic [AD_W-1:0]     addr;
  logic [CNT_W-1:0]    remaining;

  logic                p_vld;
  logic [BA_W-1:0]     p_bank;
  logic [AD_W-1:0]     p_addr;
  logic [DATA_W-1:0]   p_gold;

  logic                issue;
  logic [DATA_W-1:0]   rword;
  logic [DATA_W+1:0]   ext_r;
  logic [DATA_W+1:0]   ext_g;
  logic [DATA_W+1:0]   diff;
  logic [DATA_W+1:0]   mag;
  logic                mismatch;

  // Issue is a same-cycle handshake, so the read strobe follows gold_valid_i.
  assign issue        = (state == RUN) && gold_valid_i;
  assign gold_ready_o = issue;
  assign mem_cs_o     = issue ? (NUM_BANKS'(1) << bank) : '0;
  assign mem_addr_o   = addr;

  assign busy_o = (state == RUN) || (state == DRAIN);
  assign done_o = (state == DONE);
  assign pass_o = done_o && (err_cnt_o == '0) && !range_err_o;

  always_comb begin
    rword = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (p_bank == BA_W'(b)) rword = mem_rdata_i[b*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    ext_r    = {{(DATA_W + 2 - CMP_W){rword[CMP_W-1]}}, rword[CMP_W-1:0]};
    ext_g    = {{2{p_gold[DATA_W-1]}}, p_gold};
    diff     = ext_r - ext_g;
    mag      = diff[DATA_W+1] ? (~diff + 1'b1) : diff;
    mismatch = mag > (DATA_W + 2)'(tol_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bank            <= '0;
      addr            <= '0;
      remaining       <= '0;
      p_vld           <= 1'b0;
      p_bank          <= '0;
      p_addr          <= '0;
      p_gold          <= '0;
      err_cnt_o       <= '0;
      chk_cnt_o       <= '0;
      first_err_idx_o <= '0;
      first_err_vld_o <= 1'b0;
      range_err_o     <= 1'b0;
    end else begin
      p_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            bank            <= beg_bank_i;
            addr            <= beg_addr_i;
            remaining       <= count_i;
            err_cnt_o       <= '0;
            chk_cnt_o       <= '0;
            first_err_idx_o <= '0;
            first_err_vld_o <= 1'b0;
            range_err_o     <= 1'b0;
            state           <= (count_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (gold_valid_i) begin
            p_vld     <= 1'b1;
            p_bank    <= bank;
            p_addr    <= addr;
            p_gold    <= gold_data_i;
            remaining <= remaining - CNT_W'(1);
            if (addr == LAST_ADDR) begin
              addr <= '0;
              bank <= bank + BA_W'(1);
            end else begin
              addr <= addr + AD_W'(1);
            end
            // Overrun is detected before the bank counter would leave range,
            // so it also works when NUM_BANKS is a power of two.
            if (remaining == CNT_W'(1)) begin
              state <= DRAIN;
            end else if (addr == LAST_ADDR && bank == LAST_BANK) begin
              range_err_o <= 1'b1;
              state       <= DRAIN;
            end
          end
        end
        DRAIN: state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (p_vld) begin
        chk_cnt_o <= chk_cnt_o + CNT_W'(1);
        if (mismatch) begin
          if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_W'(1);
          if (!first_err_vld_o) begin
            first_err_idx_o <= {p_bank, p_addr};
            first_err_vld_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bank_result_checker.sv
// Scoreboard bench for bank_result_checker: reference model from linear word
// indices, read-address monitor and end-of-run result monitor.
module tb_bank_result_checker;
  localparam int unsigned NB = 6, DEPTH = 32768, DW = 16, TW = 4, EW = 4;
  localparam int unsigned BW = 3, AW = 15, NW = 18;
  localparam int TOTAL = NB * DEPTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [BW-1:0]     beg_bank_i;
  logic [AW-1:0]     beg_addr_i;
  logic [NW-1:0]     count_i;
  logic [TW-1:0]     tol_i;
  logic [NB-1:0]     mem_cs_o;
  logic [AW-1:0]     mem_addr_o;
  logic [NB*DW-1:0]  mem_rdata_i;
  logic              gold_valid_i;
  logic [DW-1:0]     gold_data_i;
  logic              gold_ready_o, busy_o, done_o, pass_o;
  logic [EW-1:0]     err_cnt_o;
  logic [NW-1:0]     chk_cnt_o;
  logic [BW+AW-1:0]  first_err_idx_o;
  logic              first_err_vld_o, range_err_o;

  bank_result_checker #(.NUM_BANKS(NB), .BANK_DEPTH(DEPTH), .DATA_W(DW), .CMP_W(8),
                        .TOL_W(TW), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .beg_bank_i(beg_bank_i),
    .beg_addr_i(beg_addr_i), .count_i(count_i), .tol_i(tol_i),
    .mem_cs_o(mem_cs_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .gold_valid_i(gold_valid_i), .gold_data_i(gold_data_i), .gold_ready_o(gold_ready_o),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
    .chk_cnt_o(chk_cnt_o), .first_err_idx_o(first_err_idx_o),
    .first_err_vld_o(first_err_vld_o), .range_err_o(range_err_o));

  always #5 clk = ~clk;

  typedef struct {
    int err; int chk; bit fvld; int fidx; bit rng; bit pass; int lat;
  } res_t;

  int          checks = 0, failures = 0;
  int          cyc = 0, start_cyc = 0;
  res_t        exp_q[$];
  int          addr_q[$];
  logic [15:0] gold_a[$];
  logic [15:0] ovr[int];

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_at(int lin);
    if (ovr.exists(lin)) return ovr[lin];
    return 16'(lin * 40503 + (lin >> 5) * 7 + 16'h3c5a);
  endfunction

  function automatic int sext8(logic [15:0] w);
    logic signed [7:0] s;
    s = w[7:0];
    return int'(s);
  endfunction

  function automatic int sext16(logic [15:0] w);
    logic signed [15:0] s;
    s = w;
    return int'(s);
  endfunction

  // SRAM model with one-cycle latency; also checks each read address in order.
  always begin : mem_model
    logic [NB*DW-1:0] nxt;
    int mb;
    @(negedge clk);
    #4;
    for (int b = 0; b < NB; b++) nxt[b*DW +: DW] = 16'($urandom);
    if (|mem_cs_o) begin
      mb = 0;
      for (int b = 0; b < NB; b++) if (mem_cs_o[b]) mb = b;
      check("cs_onehot", $countones(mem_cs_o), 1);
      if (addr_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_addr", (mb << AW) | int'(mem_addr_o), addr_q.pop_front());
      nxt[mb*DW +: DW] = mem_at(mb * DEPTH + int'(mem_addr_o));
    end
    @(posedge clk);
    #1;
    mem_rdata_i = nxt;
  end

  always @(negedge clk) begin : result_mon
    res_t e;
    if (!rst && done_o) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("err_cnt", err_cnt_o, e.err);
        check("chk_cnt", chk_cnt_o, e.chk);
        check("first_vld", first_err_vld_o, e.fvld);
        if (e.fvld) check("first_idx", first_err_idx_o, e.fidx);
        check("range_err", range_err_o, e.rng);
        check("pass", pass_o, e.pass);
        if (e.lat >= 0) check("done_cycle", cyc - start_cyc + 1, e.lat);
      end
    end
  end

  // mode 0: gold always valid; 1: valid on odd cycles; 2: random valid
  task automatic run_txn(int bb, int ba, int cnt, int tl, int mode);
    res_t e;
    int idx0, n_iss, errs, lin, d, k, c, budget;
    bit busy_ok, got_done;
    idx0  = bb * DEPTH + ba;
    n_iss = (cnt < TOTAL - idx0) ? cnt : TOTAL - idx0;
    errs = 0; e.fvld = 0; e.fidx = 0;
    for (int i = 0; i < n_iss; i++) begin
      lin = idx0 + i;
      addr_q.push_back(((lin / DEPTH) << AW) | (lin % DEPTH));
      d = sext8(mem_at(lin)) - sext16(gold_a[i]);
      if (d < 0) d = -d;
      if (d > tl) begin
        errs++;
        if (!e.fvld) begin e.fvld = 1; e.fidx = ((lin / DEPTH) << AW) | (lin % DEPTH); end
      end
    end
    e.err  = (errs > (1 << EW) - 1) ? (1 << EW) - 1 : errs;
    e.chk  = n_iss;
    e.rng  = cnt > n_iss;
    e.pass = (errs == 0) && !e.rng;
    if (mode == 0) e.lat = (cnt == 0) ? 1 : n_iss + 2;
    else if (mode == 1) e.lat = (cnt == 0) ? 1 : 2 * n_iss + 1;
    else e.lat = -1;
    exp_q.push_back(e);

    @(negedge clk);
    beg_bank_i = BW'(bb); beg_addr_i = AW'(ba); count_i = NW'(cnt); tol_i = TW'(tl);
    start_i = 1'b1; gold_valid_i = 1'b0;
    @(posedge clk);
    #1 start_cyc = cyc;
    k = 0; busy_ok = 1; got_done = 0; budget = 3 * cnt + 10;
    for (c = 1; c <= budget; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) begin
        got_done = 1;
        if (busy_o) busy_ok = 0;
        break;
      end
      if (!busy_o) busy_ok = 0;
      gold_valid_i = (k < cnt) && (mode == 0 || (mode == 1 && c % 2 == 1) ||
                                   (mode == 2 && $urandom_range(0, 3) != 0));
      gold_data_i = (k < cnt) ? gold_a[k] : 16'($urandom);
      #4;
      if (gold_valid_i && gold_ready_o) k++;
    end
    gold_valid_i = 1'b0;
    check("busy_window", busy_ok, 1);
    check("gold_consumed", k, n_iss);
    if (!got_done) begin
      check("done_timeout", 0, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      addr_q.delete();
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic fill_match(int bb, int ba, int n);
    int lin;
    gold_a.delete();
    for (int i = 0; i < n; i++) begin
      lin = bb * DEPTH + ba + i;
      gold_a.push_back((lin < TOTAL) ? 16'(sext8(mem_at(lin))) : 16'($urandom));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bb, ba, cnt, tl, lin, base, off, r;
    rst = 1'b1; start_i = 1'b0; beg_bank_i = '0; beg_addr_i = '0; count_i = '0;
    tol_i = '0; gold_valid_i = 1'b0; gold_data_i = '0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {mem_cs_o, gold_ready_o, busy_o, done_o, pass_o, range_err_o,
                        first_err_vld_o}, 0);
    check("rst_counts", {err_cnt_o, chk_cnt_o, first_err_idx_o}, 0);
    @(negedge clk) rst = 1'b0;

    fill_match(0, 0, 16);
    run_txn(0, 0, 16, 1, 0);

    ovr[100] = 16'h127F; ovr[101] = 16'h347F; ovr[102] = 16'hAB80;
    gold_a.delete();
    gold_a.push_back(16'h0080); gold_a.push_back(16'h0081); gold_a.push_back(16'hFF7F);
    run_txn(0, 100, 3, 1, 0);

    fill_match(0, 32766, 4);
    gold_a[2] = gold_a[2] ^ 16'h0040;
    run_txn(0, 32766, 4, 1, 0);

    fill_match(5, 32767, 3);
    run_txn(5, 32767, 3, 1, 0);

    fill_match(1, 10, 8);
    run_txn(1, 10, 8, 0, 1);

    fill_match(2, 0, 20);
    for (int i = 0; i < 20; i++) gold_a[i] = gold_a[i] + 16'd50;
    run_txn(2, 0, 20, 0, 0);

    gold_a.delete();
    run_txn(3, 5, 0, 2, 0);

    for (int t = 0; t < 25; t++) begin
      bb  = $urandom_range(0, NB - 1);
      ba  = ($urandom_range(0, 1) == 1) ? $urandom_range(DEPTH - 20, DEPTH - 1)
                                        : $urandom_range(0, DEPTH - 1);
      cnt = $urandom_range(0, 40);
      tl  = $urandom_range(0, 15);
      gold_a.delete();
      for (int i = 0; i < cnt; i++) begin
        lin  = bb * DEPTH + ba + i;
        base = (lin < TOTAL) ? sext8(mem_at(lin)) : 0;
        r    = $urandom_range(0, 9);
        if (r < 6) off = $urandom_range(0, 2 * tl) - tl;
        else if (r < 8) off = ($urandom_range(0, 1) == 1) ? tl + 1 : -(tl + 1);
        else off = $urandom_range(0, 65535) - base;
        gold_a.push_back(16'(base + off));
      end
      run_txn(bb, ba, cnt, tl, $urandom_range(0, 2));
    end

    fill_match(0, 0, 100);
    for (int i = 0; i < 100; i++) addr_q.push_back(i);
    @(negedge clk);
    beg_bank_i = '0; beg_addr_i = '0; count_i = NW'(100); tol_i = TW'(1); start_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_i = 1'b0; gold_valid_i = 1'b1; gold_data_i = gold_a[c-1];
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_cs", mem_cs_o, 0);
    check("rst_mid_cnts", {done_o, chk_cnt_o, err_cnt_o}, 0);
    addr_q.delete();
    @(negedge clk);
    rst = 1'b0; gold_valid_i = 1'b0;
    gold_a.delete();
    run_txn(0, 0, 0, 1, 0);

    repeat (3) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("addr_q_drained", addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
